// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the push-button debouncer array.
// Default timings assume a 50 MHz clock with tick_en tied high.
package debounce_pkg;

  localparam int unsigned DB_CYCLES_DEF  = 500_000;
  localparam int unsigned RPT_DELAY_DEF  = 25_000_000;
  localparam int unsigned RPT_PERIOD_DEF = 5_000_000;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_debounce_array_if.sv
// Button bus between the board pins, the debouncer array and the controller FSM.
interface btn_debounce_array_if #(
  parameter int unsigned N_CH = 4
);

  logic            tick_en;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] btn_repeat;
  logic            any_press;

  modport master (
    output tick_en, btn_in,
    input  btn_level, btn_press, btn_release, btn_repeat, any_press
  );

  modport slave (
    input  tick_en, btn_in,
    output btn_level, btn_press, btn_release, btn_repeat, any_press
  );

endinterface

// File: rtl/debounce_channel.sv
// One debounced button: 2-FF sync, stability counter, clean level, press/release pulses.
// DEBOUNCE_REPEAT_EN adds a hold counter that emits auto-repeat pulses while pressed.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
  parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick_en,
  input  logic pin,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt,
  output logic press_c
);

  localparam int unsigned     CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt, press_nxt, rel_nxt;

  // A differing sample only counts on ticks; any return to the stable value clears
  always_comb begin
    cnt_nxt   = cnt;
    level_nxt = level;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    if (s2 == level) begin
      cnt_nxt = '0;
    end else if (tick_en) begin
      if (cnt == CNT_LAST) begin
        level_nxt = s2;
        cnt_nxt   = '0;
        press_nxt = s2;
        rel_nxt   = ~s2;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s1    <= pin ^ ACTIVE_LOW;
      s2    <= s1;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
    end
  end

  assign press_c = press_nxt;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int unsigned   HW          = cnt_width(RPT_DELAY);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(RPT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(RPT_DELAY - RPT_PERIOD);

  logic [HW-1:0] hold, hold_nxt;
  logic          rpt_nxt;

  // Reload after each repeat so later repeats come every RPT_PERIOD ticks
  always_comb begin
    hold_nxt = hold;
    rpt_nxt  = 1'b0;
    if (!(level && level_nxt)) begin
      hold_nxt = '0;
    end else if (tick_en) begin
      if (hold == HOLD_LAST) begin
        rpt_nxt  = 1'b1;
        hold_nxt = HOLD_RELOAD;
      end else begin
        hold_nxt = hold + HW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold <= '0;
      rpt  <= 1'b0;
    end else begin
      hold <= hold_nxt;
      rpt  <= rpt_nxt;
    end
  end
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_array.sv
// N-channel push-button debouncer between the board pins and the controller FSM.
// Define DEBOUNCE_REPEAT_EN to enable per-channel auto-repeat pulses.
module btn_debounce_array
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
  parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF
) (
  input logic                 CLK,
  input logic                 RST,
  btn_debounce_array_if.slave bus
);

  logic [N_CH-1:0] level_w, press_w, rel_w, rpt_w, press_c;
  logic            any_press_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW),
      .RPT_DELAY  (RPT_DELAY),
      .RPT_PERIOD (RPT_PERIOD)
    ) u_ch (
      .CLK     (CLK),
      .RST     (RST),
      .tick_en (bus.tick_en),
      .pin     (bus.btn_in[i]),
      .level   (level_w[i]),
      .press   (press_w[i]),
      .rel     (rel_w[i]),
      .rpt     (rpt_w[i]),
      .press_c (press_c[i])
    );
  end

  // Registered from the next-cycle press bits so it lines up with btn_press
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_c;
    end
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = rel_w;
  assign bus.btn_repeat  = rpt_w;
  assign bus.any_press   = any_press_q;

endmodule

// File: tb/tb_btn_debounce_array.sv
// Directed bench for btn_debounce_array (N_CH=4, DB_CYCLES=8, RPT_DELAY=20, RPT_PERIOD=5).
module tb_btn_debounce_array;

  logic CLK = 1'b0;
  logic RST;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [3:0] rpt_seen = '0;

  btn_debounce_array_if #(.N_CH(4)) bus ();

  btn_debounce_array #(
    .N_CH       (4),
    .DB_CYCLES  (8),
    .ACTIVE_LOW (1'b0),
    .RPT_DELAY  (20),
    .RPT_PERIOD (5)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) rpt_seen <= rpt_seen | bus.btn_repeat;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [3:0]  seen;
    int          press_edge;
    int          press_cnt;
    int          rel_edge;
    logic [79:0] obs_mask;
    logic [79:0] exp_mask;

    RST         = 1'b1;
    bus.btn_in  = 4'hF;
    bus.tick_en = 1'b1;
    step(3);
    check("rst_level",   128'(bus.btn_level),   128'(4'h0));
    check("rst_press",   128'(bus.btn_press),   128'(4'h0));
    check("rst_release", 128'(bus.btn_release), 128'(4'h0));
    check("rst_repeat",  128'(bus.btn_repeat),  128'(4'h0));
    check("rst_any",     128'(bus.any_press),   128'(1'b0));

    // 1: all pins held through reset
    RST = 1'b0;
    step(9);
    check("t1_level_early", 128'(bus.btn_level), 128'(4'h0));
    check("t1_press_early", 128'(bus.btn_press), 128'(4'h0));
    step(1);
    check("t1_level", 128'(bus.btn_level), 128'(4'hF));
    check("t1_press", 128'(bus.btn_press), 128'(4'hF));
    check("t1_any",   128'(bus.any_press), 128'(1'b1));
    step(1);
    check("t1_press_one_cycle", 128'(bus.btn_press), 128'(4'h0));
    check("t1_any_one_cycle",   128'(bus.any_press), 128'(1'b0));

    bus.btn_in = 4'h0;
    step(10);
    check("t1_release_all", 128'(bus.btn_release), 128'(4'hF));
    check("t1_level_off",   128'(bus.btn_level),   128'(4'h0));
    step(1);
    check("t1_release_one_cycle", 128'(bus.btn_release), 128'(4'h0));

    // 2: ch0 bounces with 3-clock runs, then settles high
    seen = '0;
    for (int k = 0; k < 10; k++) begin
      bus.btn_in[0] = (k % 2 == 0);
      for (int c = 0; c < 3; c++) begin
        step(1);
        seen = seen | bus.btn_press | bus.btn_release | bus.btn_level;
      end
    end
    check("t2_bounce_quiet", 128'(seen), 128'(4'h0));
    bus.btn_in[0] = 1'b1;
    step(9);
    check("t2_press_early", 128'(bus.btn_press), 128'(4'h0));
    step(1);
    check("t2_press", 128'(bus.btn_press), 128'(4'h1));
    check("t2_level", 128'(bus.btn_level), 128'(4'h1));

    // 3: ch1 press then release
    bus.btn_in[1] = 1'b1;
    step(10);
    check("t3_press", 128'(bus.btn_press), 128'(4'h2));
    check("t3_level_on", 128'(bus.btn_level), 128'(4'h3));
    bus.btn_in[1] = 1'b0;
    step(10);
    check("t3_release", 128'(bus.btn_release), 128'(4'h2));
    check("t3_level_off", 128'(bus.btn_level), 128'(4'h1));
    check("t3_no_press", 128'(bus.btn_press), 128'(4'h0));
    step(1);
    check("t3_release_one_cycle", 128'(bus.btn_release), 128'(4'h0));

    // 4: tick_en every 4th clock, clean step on ch2
    bus.btn_in[2] = 1'b1;
    press_edge = -1;
    press_cnt  = 0;
    for (int k = 0; k < 40; k++) begin
      bus.tick_en = (k % 4 == 3);
      step(1);
      if (bus.btn_press[2]) begin
        press_cnt++;
        if (press_edge < 0) press_edge = k + 1;
      end
    end
    bus.tick_en = 1'b1;
    check("t4_press_edge",  128'(press_edge), 128'(32));
    check("t4_press_count", 128'(press_cnt),  128'(1));
    check("t4_level",       128'(bus.btn_level), 128'(4'h5));

    // 4b: freeze mid-count on ch2 release, then resume
    bus.btn_in[2] = 1'b0;
    step(6);
    bus.tick_en = 1'b0;
    step(20);
    check("t4_frozen_level",   128'(bus.btn_level),   128'(4'h5));
    check("t4_frozen_release", 128'(bus.btn_release), 128'(4'h0));
    bus.tick_en = 1'b1;
    step(3);
    check("t4_resume_early", 128'(bus.btn_release), 128'(4'h0));
    step(1);
    check("t4_release", 128'(bus.btn_release), 128'(4'h4));
    check("t4_level_off", 128'(bus.btn_level), 128'(4'h1));

    // 5: reset while ch3 is at count 5
    bus.btn_in[3] = 1'b1;
    step(7);
    RST = 1'b1;
    #1;
    check("t5_rst_level", 128'(bus.btn_level), 128'(4'h0));
    check("t5_rst_press", 128'(bus.btn_press), 128'(4'h0));
    check("t5_rst_any",   128'(bus.any_press), 128'(1'b0));
    step(2);
    RST  = 1'b0;
    seen = '0;
    for (int c = 0; c < 9; c++) begin
      step(1);
      seen = seen | bus.btn_press | bus.btn_release | bus.btn_level;
    end
    check("t5_no_spurious", 128'(seen), 128'(4'h0));
    step(1);
    check("t5_press", 128'(bus.btn_press), 128'(4'h9));
    check("t5_level", 128'(bus.btn_level), 128'(4'h9));
    check("t5_any",   128'(bus.any_press), 128'(1'b1));

    bus.btn_in = 4'h0;
    step(10);
    check("t5_release", 128'(bus.btn_release), 128'(4'h9));
    step(2);

`ifdef DEBOUNCE_REPEAT_EN
    // 6: hold ch0, release timed to land on a repeat slot
    bus.btn_in[0] = 1'b1;
    step(10);
    check("t6_press", 128'(bus.btn_press), 128'(4'h1));
    check("t6_no_rpt_on_press", 128'(bus.btn_repeat), 128'(4'h0));
    obs_mask = '0;
    exp_mask = '0;
    exp_mask[20] = 1'b1;
    exp_mask[25] = 1'b1;
    exp_mask[30] = 1'b1;
    exp_mask[35] = 1'b1;
    exp_mask[40] = 1'b1;
    exp_mask[45] = 1'b1;
    exp_mask[50] = 1'b1;
    rel_edge = -1;
    for (int j = 1; j < 70; j++) begin
      step(1);
      obs_mask[j] = bus.btn_repeat[0];
      if (bus.btn_release[0] && rel_edge < 0) rel_edge = j;
      if (j == 45) bus.btn_in[0] = 1'b0;
    end
    check("t6_repeat_mask", 128'(obs_mask), 128'(exp_mask));
    check("t6_release_edge", 128'(rel_edge), 128'(55));
    check("t6_level_off", 128'(bus.btn_level), 128'(4'h0));
`else
    check("rpt_tied_zero", 128'(rpt_seen), 128'(4'h0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
